// File: rtl/fft_pkg.sv
// Shared types, constants and helpers for the 32-point radix-2 FFT.
// Optional per-stage 1/2 scaling is selected by macro FFT_STAGE_SCALE_EN.
package fft_pkg;

   localparam int N      = 32;
   localparam int LOGN   = 5;
   localparam int DATA_W = 16;
   localparam int TW_W   = 16;

   typedef struct packed {
      logic signed [DATA_W-1:0] re;
      logic signed [DATA_W-1:0] im;
   } cplx_t;

   typedef struct packed {
      logic signed [TW_W-1:0] re;
      logic signed [TW_W-1:0] im;
   } tw_t;

   typedef enum logic [1:0] {
      LOAD    = 2'd0,
      COMPUTE = 2'd1,
      OUTPUT  = 2'd2
   } state_t;

   // W_k = cos(2*pi*k/32) - j*sin(2*pi*k/32), Q1.14, k = 0..15
   localparam tw_t TW_ROM [16] = '{
      '{ 16'sd16384,  16'sd0     },
      '{ 16'sd16069, -16'sd3196  },
      '{ 16'sd15137, -16'sd6270  },
      '{ 16'sd13623, -16'sd9102  },
      '{ 16'sd11585, -16'sd11585 },
      '{ 16'sd9102,  -16'sd13623 },
      '{ 16'sd6270,  -16'sd15137 },
      '{ 16'sd3196,  -16'sd16069 },
      '{ 16'sd0,     -16'sd16384 },
      '{-16'sd3196,  -16'sd16069 },
      '{-16'sd6270,  -16'sd15137 },
      '{-16'sd9102,  -16'sd13623 },
      '{-16'sd11585, -16'sd11585 },
      '{-16'sd13623, -16'sd9102  },
      '{-16'sd15137, -16'sd6270  },
      '{-16'sd16069, -16'sd3196  }
   };

   function automatic logic [LOGN-1:0] bitrev5(input logic [LOGN-1:0] v);
      return {v[0], v[1], v[2], v[3], v[4]};
   endfunction

endpackage

// File: rtl/fft_butterfly.sv
// Combinational radix-2 DIT butterfly: A' = A + B*W, B' = A - B*W.
// With FFT_STAGE_SCALE_EN both results are halved (floor) to avoid growth.
module fft_butterfly
   import fft_pkg::*;
(
   input  cplx_t i_a,
   input  cplx_t i_b,
   input  tw_t   i_w,
   output cplx_t o_a,
   output cplx_t o_b
);

   logic signed [15:0] w_a_re;
   logic signed [15:0] w_a_im;
   logic signed [15:0] w_b_re;
   logic signed [15:0] w_b_im;
   logic signed [15:0] w_w_re;
   logic signed [15:0] w_w_im;

   logic signed [31:0] w_p_rr;
   logic signed [31:0] w_p_ii;
   logic signed [31:0] w_p_ri;
   logic signed [31:0] w_p_ir;

   logic signed [32:0] w_sum_re;
   logic signed [32:0] w_sum_im;
   logic signed [17:0] w_t_re;
   logic signed [17:0] w_t_im;

   logic signed [18:0] w_xa_re;
   logic signed [18:0] w_xa_im;
   logic signed [18:0] w_xb_re;
   logic signed [18:0] w_xb_im;

   assign w_a_re = i_a.re;
   assign w_a_im = i_a.im;
   assign w_b_re = i_b.re;
   assign w_b_im = i_b.im;
   assign w_w_re = i_w.re;
   assign w_w_im = i_w.im;

   // full-precision complex product B*W
   assign w_p_rr = w_b_re * w_w_re;
   assign w_p_ii = w_b_im * w_w_im;
   assign w_p_ri = w_b_re * w_w_im;
   assign w_p_ir = w_b_im * w_w_re;

   // round to nearest: add half an LSB of Q1.14, then drop 14 bits
   assign w_sum_re = 33'(w_p_rr) - 33'(w_p_ii) + 33'sd8192;
   assign w_sum_im = 33'(w_p_ri) + 33'(w_p_ir) + 33'sd8192;
   assign w_t_re   = 18'(w_sum_re >>> 14);
   assign w_t_im   = 18'(w_sum_im >>> 14);

   // exact sums kept wide so the scaled path sees the carry bit
   assign w_xa_re = 19'(w_a_re) + 19'(w_t_re);
   assign w_xa_im = 19'(w_a_im) + 19'(w_t_im);
   assign w_xb_re = 19'(w_a_re) - 19'(w_t_re);
   assign w_xb_im = 19'(w_a_im) - 19'(w_t_im);

`ifdef FFT_STAGE_SCALE_EN
   assign o_a.re = 16'(w_xa_re >>> 1);
   assign o_a.im = 16'(w_xa_im >>> 1);
   assign o_b.re = 16'(w_xb_re >>> 1);
   assign o_b.im = 16'(w_xb_im >>> 1);
`else
   assign o_a.re = 16'(w_xa_re);
   assign o_a.im = 16'(w_xa_im);
   assign o_b.re = 16'(w_xb_re);
   assign o_b.im = 16'(w_xb_im);
`endif

endmodule

// File: rtl/top.sv
// 32-point in-place radix-2 FFT: load 32 samples, 80 butterflies, stream bins.
// Build option FFT_STAGE_SCALE_EN enables 1/2 scaling in every butterfly stage.
module top
   import fft_pkg::*;
(
   input  logic                     clk,
   input  logic                     reset,
   input  logic signed [DATA_W-1:0] data_i_r,
   input  logic signed [DATA_W-1:0] data_i_i,
   output logic signed [DATA_W-1:0] data_o_r,
   output logic signed [DATA_W-1:0] data_o_i,
   output logic                     res_ready
);

   state_t      r_state;
   state_t      w_nxt_state;
   logic [4:0]  r_cnt;
   logic [4:0]  w_nxt_cnt;
   logic [2:0]  r_stage;
   logic [2:0]  w_nxt_stage;

   logic        w_ld_we;
   logic        w_bf_we;
   logic        w_out_en;

   cplx_t       r_mem [N];
   cplx_t       r_dout;
   logic        r_res_ready;

   logic [4:0]  w_bf;
   logic [4:0]  w_mask;
   logic [4:0]  w_hi;
   logic [4:0]  w_pa;
   logic [4:0]  w_pb;
   logic [3:0]  w_k;

   cplx_t       w_a;
   cplx_t       w_b;
   cplx_t       w_ya;
   cplx_t       w_yb;
   cplx_t       w_din;
   tw_t         w_w;

   // butterfly operand addresses and twiddle index for (stage, butterfly)
   assign w_bf   = {1'b0, r_cnt[3:0]};
   assign w_mask = (5'd1 << r_stage) - 5'd1;
   assign w_hi   = (w_bf >> r_stage) << (r_stage + 3'd1);
   assign w_pa   = w_hi | (w_bf & w_mask);
   assign w_pb   = w_pa | (5'd1 << r_stage);
   assign w_k    = 4'((w_bf & w_mask) << (3'd4 - r_stage));

   assign w_a    = r_mem[w_pa];
   assign w_b    = r_mem[w_pb];
   assign w_w    = TW_ROM[w_k];

   assign w_din.re = data_i_r;
   assign w_din.im = data_i_i;

   fft_butterfly u_bfly (
      .i_a (w_a),
      .i_b (w_b),
      .i_w (w_w),
      .o_a (w_ya),
      .o_b (w_yb)
   );

   // state, counter and stage registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= LOAD;
         r_cnt   <= '0;
         r_stage <= '0;
      end else begin
         r_state <= w_nxt_state;
         r_cnt   <= w_nxt_cnt;
         r_stage <= w_nxt_stage;
      end
   end

   // next-state logic and per-state strobes
   always_comb begin
      w_nxt_state = r_state;
      w_nxt_cnt   = r_cnt + 5'd1;
      w_nxt_stage = r_stage;
      w_ld_we     = 1'b0;
      w_bf_we     = 1'b0;
      w_out_en    = 1'b0;
      unique case (r_state)
         LOAD: begin
            w_ld_we     = 1'b1;
            w_nxt_stage = '0;
            if (r_cnt == 5'd31) begin
               w_nxt_state = COMPUTE;
            end
         end
         COMPUTE: begin
            w_bf_we = 1'b1;
            if (r_cnt[3:0] == 4'd15) begin
               w_nxt_cnt   = '0;
               w_nxt_stage = r_stage + 3'd1;
               if (r_stage == 3'd4) begin
                  w_nxt_state = OUTPUT;
                  w_nxt_stage = '0;
               end
            end
         end
         OUTPUT: begin
            w_out_en = 1'b1;
            if (r_cnt == 5'd31) begin
               w_nxt_state = LOAD;
            end
         end
         default: begin
            w_nxt_state = LOAD;
            w_nxt_cnt   = '0;
            w_nxt_stage = '0;
         end
      endcase
   end

   // sample buffer: bit-reversed load, then in-place butterfly writeback
   always_ff @(posedge clk) begin
      if (!reset && w_ld_we) begin
         r_mem[bitrev5(r_cnt)] <= w_din;
      end else if (!reset && w_bf_we) begin
         r_mem[w_pa] <= w_ya;
         r_mem[w_pb] <= w_yb;
      end
   end

   // registered output: one bin per cycle in natural order, zero otherwise
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_dout      <= '0;
         r_res_ready <= 1'b0;
      end else if (w_out_en) begin
         r_dout      <= r_mem[r_cnt];
         r_res_ready <= 1'b1;
      end else begin
         r_dout      <= '0;
         r_res_ready <= 1'b0;
      end
   end

   assign data_o_r  = r_dout.re;
   assign data_o_i  = r_dout.im;
   assign res_ready = r_res_ready;

endmodule

// File: tb/tb_top.sv
// Self-checking bench for the 32-point FFT: directed frames plus random frames
// compared against a floating-point DFT with per-frame tolerance.
module tb_top;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic signed [15:0] data_i_r = '0;
   logic signed [15:0] data_i_i = '0;
   logic signed [15:0] data_o_r;
   logic signed [15:0] data_o_i;
   logic               res_ready;

   int  checks   = 0;
   int  failures = 0;
   int  xr [32];
   int  xi [32];
   real er [32];
   real ei [32];
   int  tol;

   localparam real PI = 3.14159265358979323846;

   always #5 clk = ~clk;

   top dut (
      .clk       (clk),
      .reset     (reset),
      .data_i_r  (data_i_r),
      .data_i_i  (data_i_i),
      .data_o_r  (data_o_r),
      .data_o_i  (data_o_i),
      .res_ready (res_ready)
   );

   // direct DFT of the current frame
   task automatic model();
      real sr, si, c, s, ang;
      for (int k = 0; k < 32; k++) begin
         sr = 0.0;
         si = 0.0;
         for (int n = 0; n < 32; n++) begin
            ang = -2.0 * PI * real'((k * n) % 32) / 32.0;
            c = $cos(ang);
            s = $sin(ang);
            sr += real'(xr[n]) * c - real'(xi[n]) * s;
            si += real'(xr[n]) * s + real'(xi[n]) * c;
         end
`ifdef FFT_STAGE_SCALE_EN
         sr = sr / 32.0;
         si = si / 32.0;
`endif
         er[k] = sr;
         ei[k] = si;
      end
   endtask

   task automatic set_tol(input int t);
`ifdef FFT_STAGE_SCALE_EN
      tol = 3;
`else
      tol = t;
`endif
   endtask

   task automatic chk_bit(input string tag, input logic got, input logic exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0b want=%0b", tag, got, exp);
      end
   endtask

   task automatic chk16(input string tag, input logic [15:0] got,
                        input logic [15:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0h want=%0h", tag, got, exp);
      end
   endtask

   task automatic chk_bin(input int k);
      int  gr, gi;
      real dr, di, lim;
      bit  ok;
      gr  = int'(data_o_r);
      gi  = int'(data_o_i);
      dr  = real'(gr) - er[k];
      di  = real'(gi) - ei[k];
      lim = real'(tol) + 0.001;
      ok  = (dr <= lim) && (dr >= -lim) && (di <= lim) && (di >= -lim);
      checks++;
      assert (ok === 1'b1) else begin
         failures++;
         $error("FAIL bin%0d got=(%0d,%0d) want=(%0.2f,%0.2f) tol=%0d",
                k, gr, gi, er[k], ei[k], tol);
      end
   endtask

   // drive one frame starting at the next edge (edge 0) and check edges 0..143
   task automatic run_frame(input int abort_at);
      model();
      for (int e = 0; e < 144; e++) begin
         if (e < 32) begin
            data_i_r = 16'(xr[e]);
            data_i_i = 16'(xi[e]);
         end else begin
            data_i_r = 16'($urandom);
            data_i_i = 16'($urandom);
         end
         @(posedge clk);
         #1;
         if (e >= 112) begin
            chk_bit("rdy_hi", res_ready, 1'b1);
            chk_bin(e - 112);
         end else begin
            chk_bit("rdy_lo", res_ready, 1'b0);
            if (e % 16 == 0) begin
               chk16("idle_re", data_o_r, 16'h0);
               chk16("idle_im", data_o_i, 16'h0);
            end
         end
         if (e == abort_at) begin
            reset = 1'b1;
            #1;
            chk_bit("abort_rdy", res_ready, 1'b0);
            chk16("abort_re", data_o_r, 16'h0);
            chk16("abort_im", data_o_i, 16'h0);
            return;
         end
      end
   endtask

   task automatic rand_frame(input int amp);
      for (int n = 0; n < 32; n++) begin
         xr[n] = int'($urandom_range(2 * amp)) - amp;
         xi[n] = int'($urandom_range(2 * amp)) - amp;
      end
   endtask

   task automatic release_reset();
      repeat (3) @(posedge clk);
      #1;
      chk_bit("rst_rdy", res_ready, 1'b0);
      chk16("rst_re", data_o_r, 16'h0);
      chk16("rst_im", data_o_i, 16'h0);
      reset = 1'b0;
   endtask

   initial begin
      // reset state, then square wave
      release_reset();
      for (int n = 0; n < 32; n++) begin
         xr[n] = ((n % 16) < 8) ? 127 : -127;
         xi[n] = 0;
      end
      set_tol(4);
      run_frame(-1);

      // back-to-back identical frame
      run_frame(-1);

      // impulse
      for (int n = 0; n < 32; n++) begin
         xr[n] = (n == 0) ? 1000 : 0;
         xi[n] = 0;
      end
      set_tol(0);
      run_frame(-1);

      // DC
      for (int n = 0; n < 32; n++) begin
         xr[n] = 100;
         xi[n] = 0;
      end
      set_tol(2);
      run_frame(-1);

      // complex tone in bin 3
      for (int n = 0; n < 32; n++) begin
         xr[n] = int'(500.0 * $cos(2.0 * PI * real'(3 * n) / 32.0));
         xi[n] = int'(500.0 * $sin(2.0 * PI * real'(3 * n) / 32.0));
      end
      set_tol(8);
      run_frame(-1);

      // random frames
      for (int f = 0; f < 3; f++) begin
         rand_frame(700);
         set_tol(8);
         run_frame(-1);
      end

      // reset mid-compute, then a fresh frame
      rand_frame(700);
      run_frame(50);
      release_reset();
      rand_frame(700);
      run_frame(-1);

      // reset mid-output, then a fresh frame
      rand_frame(700);
      run_frame(120);
      release_reset();
      rand_frame(700);
      run_frame(-1);

      // output window closes on edge 144
      data_i_r = '0;
      data_i_i = '0;
      @(posedge clk);
      #1;
      chk_bit("fall_rdy", res_ready, 1'b0);
      chk16("fall_re", data_o_r, 16'h0);
      chk16("fall_im", data_o_i, 16'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
